// File: rtl/axi4_enc_pkg.sv
// Shared types and constants for the AXI4 write-burst encoder.
package axi4_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } enc_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned BYTES_PER_BEAT = 32;
    localparam int unsigned DW_PER_BEAT    = 8;

    // Number of 32-byte beats needed to carry len_dw doublewords (ceiling).
    function automatic logic [8:0] dw_to_beats(input logic [7:0] len_dw);
        return ({1'b0, len_dw} + 9'd7) >> 3;
    endfunction

endpackage

// File: rtl/axi4_wstrb_gen.sv
// Byte-strobe generator for one 32-byte W beat: full strobe except a
// partially filled last beat, which enables only its low 4*rem bytes.
module axi4_wstrb_gen
    import axi4_enc_pkg::*;
(
    input  logic                      i_is_last,
    input  logic [2:0]                i_rem,
    output logic [BYTES_PER_BEAT-1:0] o_wstrb_c
);

    // Strobe mask from the doubleword remainder of the chunk.
    always_comb begin
        o_wstrb_c = '1;
        if (i_is_last && (i_rem != 3'd0)) begin
            o_wstrb_c = (BYTES_PER_BEAT'(1) << {i_rem, 2'b00}) - BYTES_PER_BEAT'(1);
        end
    end

endmodule

// File: rtl/axi4_if_encoding.sv
// AXI4 write master: turns one decoded memory-write chunk into a single
// INCR burst (AW, then W beats, then B). One chunk in flight at a time.
// Optional build macro AXI4_ENC_ERR_CNT_EN adds a saturating err_cnt output.
module axi4_if_encoding
    import axi4_enc_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned CHUNK_MAX_BEATS = 4,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDR_WIDTH-1:0]                 in_addr,
    input  logic [7:0]                            in_length,
    input  logic [15:0]                           in_bdf,
    input  logic                                  in_is_memwrite,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] in_wdata,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [ID_WIDTH-1:0]                   m_awid,
    output logic [ADDR_WIDTH-1:0]                 m_awaddr,
    output logic [7:0]                            m_awlen,
    output logic [2:0]                            m_awsize,
    output logic [1:0]                            m_awburst,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [DATA_WIDTH-1:0]                 m_wdata,
    output logic [DATA_WIDTH/8-1:0]               m_wstrb,
    output logic                                  m_wlast,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    input  logic [ID_WIDTH-1:0]                   m_bid,
    input  logic [1:0]                            m_bresp,
    input  logic                                  m_bvalid,
    output logic                                  m_bready,
    output logic                                  err_pulse,
    output logic                                  busy
`ifdef AXI4_ENC_ERR_CNT_EN
    ,
    output logic [15:0]                           err_cnt
`endif
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SEL_W  = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
    localparam int unsigned MAX_DW = DW_PER_BEAT * CHUNK_MAX_BEATS;

    enc_state_t                                  r_state,     w_state_next;
    logic                                        r_in_ready,  w_in_ready_next;
    logic                                        r_awvalid,   w_awvalid_next;
    logic [ADDR_WIDTH-1:0]                       r_awaddr,    w_awaddr_next;
    logic [7:0]                                  r_awlen,     w_awlen_next;
    logic                                        r_wvalid,    w_wvalid_next;
    logic [DATA_WIDTH-1:0]                       r_wdata,     w_wdata_next;
    logic [STRB_W-1:0]                           r_wstrb,     w_wstrb_next;
    logic                                        r_wlast,     w_wlast_next;
    logic                                        r_bready,    w_bready_next;
    logic                                        r_err_pulse, w_err_next;
    logic                                        r_busy,      w_busy_next;
    logic [CHUNK_MAX_BEATS-1:0][DATA_WIDTH-1:0]  r_chunk,     w_chunk_next;
    logic [2:0]                                  r_beat_idx,  w_beat_idx_next;
    logic [2:0]                                  r_rem,       w_rem_next;
    logic [15:0]                                 r_bdf,       w_bdf_next;
    logic [ID_WIDTH-1:0]                         r_bid,       w_bid_next;

    logic [8:0]                w_in_beats;
    logic                      w_chunk_ok;
    logic [2:0]                w_present_beat;
    logic                      w_present_last;
    logic [DATA_WIDTH-1:0]     w_slice;
    logic [BYTES_PER_BEAT-1:0] w_strb_c;
    logic                      w_unused;

    // Chunk classification and selection of the beat presented next on W.
    assign w_in_beats     = dw_to_beats(in_length);
    assign w_chunk_ok     = in_is_memwrite && (in_length != 8'd0) && (9'(in_length) <= 9'(MAX_DW));
    assign w_present_beat = (r_state == W) ? (r_beat_idx + 3'd1) : 3'd0;
    assign w_present_last = (w_present_beat == r_awlen[2:0]);
    assign w_slice        = r_chunk[SEL_W'(w_present_beat)];

    axi4_wstrb_gen u_wstrb_gen (
        .i_is_last (w_present_last),
        .i_rem     (r_rem),
        .o_wstrb_c (w_strb_c)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_busy      <= 1'b0;
            r_chunk     <= '0;
            r_beat_idx  <= '0;
            r_rem       <= '0;
            r_bdf       <= '0;
            r_bid       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= w_in_ready_next;
            r_awvalid   <= w_awvalid_next;
            r_awaddr    <= w_awaddr_next;
            r_awlen     <= w_awlen_next;
            r_wvalid    <= w_wvalid_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_wlast     <= w_wlast_next;
            r_bready    <= w_bready_next;
            r_err_pulse <= w_err_next;
            r_busy      <= w_busy_next;
            r_chunk     <= w_chunk_next;
            r_beat_idx  <= w_beat_idx_next;
            r_rem       <= w_rem_next;
            r_bdf       <= w_bdf_next;
            r_bid       <= w_bid_next;
        end
    end

    // Next-state and next-output logic for the IDLE/AW/W/B sequence.
    always_comb begin
        w_state_next    = r_state;
        w_in_ready_next = r_in_ready;
        w_awvalid_next  = r_awvalid;
        w_awaddr_next   = r_awaddr;
        w_awlen_next    = r_awlen;
        w_wvalid_next   = r_wvalid;
        w_wdata_next    = r_wdata;
        w_wstrb_next    = r_wstrb;
        w_wlast_next    = r_wlast;
        w_bready_next   = r_bready;
        w_err_next      = 1'b0;
        w_busy_next     = r_busy;
        w_chunk_next    = r_chunk;
        w_beat_idx_next = r_beat_idx;
        w_rem_next      = r_rem;
        w_bdf_next      = r_bdf;
        w_bid_next      = r_bid;

        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_awaddr_next = in_addr;
                    w_awlen_next  = 8'(w_in_beats - 9'd1);
                    w_rem_next    = in_length[2:0];
                    w_chunk_next  = in_wdata;
                    w_bdf_next    = in_bdf;
                    if (w_chunk_ok) begin
                        w_state_next    = AW;
                        w_awvalid_next  = 1'b1;
                        w_in_ready_next = 1'b0;
                        w_busy_next     = 1'b1;
                        w_beat_idx_next = 3'd0;
                    end else begin
                        // Unsupported or out-of-range chunk: consume and flag it.
                        w_err_next = 1'b1;
                    end
                end
            end
            AW: begin
                if (m_awready) begin
                    w_awvalid_next = 1'b0;
                    w_state_next   = W;
                    w_wvalid_next  = 1'b1;
                    w_wdata_next   = w_slice;
                    w_wstrb_next   = STRB_W'(w_strb_c);
                    w_wlast_next   = w_present_last;
                end
            end
            W: begin
                if (m_wready) begin
                    if (r_wlast) begin
                        w_wvalid_next = 1'b0;
                        w_wlast_next  = 1'b0;
                        w_state_next  = B;
                        w_bready_next = 1'b1;
                    end else begin
                        w_beat_idx_next = r_beat_idx + 3'd1;
                        w_wdata_next    = w_slice;
                        w_wstrb_next    = STRB_W'(w_strb_c);
                        w_wlast_next    = w_present_last;
                    end
                end
            end
            B: begin
                if (m_bvalid) begin
                    w_bready_next   = 1'b0;
                    w_state_next    = IDLE;
                    w_in_ready_next = 1'b1;
                    w_busy_next     = 1'b0;
                    w_bid_next      = m_bid;
                    w_err_next      = (m_bresp != AXI_RESP_OKAY);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef AXI4_ENC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (r_err_pulse && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    // BDF and BID are captured for debug visibility only.
    assign w_unused = ^{r_bdf, r_bid};

    assign in_ready  = r_in_ready;
    assign m_awid    = ID_WIDTH'(AXI_ID);
    assign m_awaddr  = r_awaddr;
    assign m_awlen   = r_awlen;
    assign m_awsize  = AXI_SIZE_32B;
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wlast   = r_wlast;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign err_pulse = r_err_pulse;
    assign busy      = r_busy;

endmodule

// File: doc/axi4_if_encoding.md
Name: axi4_if_encoding

Overview:
AXI4 write master that converts decoded memory-write chunks (address, DW length, up to CHUNK_MAX_BEATS beats of data) back into single AXI4 INCR bursts on AW/W and collects the B response. It is the inverse of the AXI-slave write decoder. It sits on the receive side of the link, after TLP parsing, and drives the local AXI interconnect. One chunk is in flight at a time.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 256, AXI data width; fixed at 256 (32 B/beat = 8 DW)
CHUNK_MAX_BEATS, 4, maximum beats per chunk/burst
AXI_ID, 0, constant awid driven on every burst

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_addr  in  ADDR_WIDTH  chunk start byte address, 32 B aligned
in_length  in  8  chunk length in DW, 1..8*CHUNK_MAX_BEATS
in_bdf  in  16  requester BDF, latched for debug only
in_is_memwrite  in  1  1 = memory write, 0 = unsupported type
in_wdata  in  DATA_WIDTH*CHUNK_MAX_BEATS  beat k at bits [256k+255:256k]
in_valid  in  1  chunk valid
in_ready  out  1  chunk accepted when in_valid && in_ready
m_awid  out  ID_WIDTH  = AXI_ID
m_awaddr  out  ADDR_WIDTH  latched in_addr
m_awlen  out  8  beats-1
m_awsize  out  3  3'd5
m_awburst  out  2  2'b01 INCR
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wdata  out  DATA_WIDTH  current beat
m_wstrb  out  DATA_WIDTH/8  byte strobes
m_wlast  out  1  last beat
m_wvalid  out  1  W valid
m_wready  in  1  W ready
m_bid  in  ID_WIDTH  ignored beyond capture
m_bresp  in  2  write response
m_bvalid  in  1  B valid
m_bready  out  1  B ready
err_pulse  out  1  one-cycle pulse on dropped chunk or non-OKAY bresp
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; in_ready=1; m_awvalid=m_wvalid=m_wlast=m_bready=err_pulse=busy=0; m_awaddr, m_awlen, m_wdata and m_wstrb = 0; beat counter = 0.
- FSM states: IDLE, AW, W, B.
  - IDLE: in_ready=1. On acceptance, latch all inputs.
  - beats = ceil(in_length/8). rem = in_length mod 8.
  - Valid chunk (is_memwrite=1 and 1<=in_length<=8*CHUNK_MAX_BEATS): next state AW.
  - Otherwise: chunk consumed and dropped, err_pulse=1 next cycle, stay IDLE.
- AW: m_awvalid=1 registered, asserted the cycle after acceptance. Fields are held stable until m_awready. On handshake, deassert and go to W.
- W: m_wvalid=1. m_wdata = slice[beat_idx].
  - m_wstrb = all ones, except on the last beat when rem!=0: low 4*rem bits set.
  - m_wlast=1 iff beat_idx==beats-1.
  - Data/strb/last are held until m_wready.
  - On a handshake with wlast, go to B. Otherwise beat_idx+1.
  - beat_idx is 3 bits wide, cleared on entry to AW.
- B: m_bready=1. On m_bvalid, go to IDLE. If m_bresp!=2'b00, err_pulse=1 for one cycle.
- Throughput and latency:
  - Minimum 1 + 1 + beats + 1 cycles per chunk with zero-wait slaves.
  - in_ready is low from the acceptance cycle+1 until back in IDLE. No overlap of chunks.
- AW is always issued before W. W is never asserted in the same cycle as AW.
- No 4 KB boundary check; the upstream guarantees chunks do not cross 4 KB.
- m_bvalid arriving in a state other than B is ignored (bready=0).
- Reset mid-burst: immediately returns to IDLE with all valids low; the partial burst is abandoned.

Optional Feature:
- Macro AXI4_ENC_ERR_CNT_EN.
- Defined: adds output err_cnt[15:0], which increments on every err_pulse and saturates at 16'hFFFF. Reset value 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Package axi4_enc_pkg holds:
  - enum enc_state_t {IDLE, AW, W, B}
  - AXI_BURST_INCR=2'b01, AXI_SIZE_32B=3'd5, AXI_RESP_OKAY=2'b00
  - BYTES_PER_BEAT=32, DW_PER_BEAT=8
- One natural sub-module: axi4_wstrb_gen. It is combinational: inputs is_last and rem[2:0], output the 32-bit strobe.
- All remaining logic stays in the top module.

Test Plan:
- Chunk addr=0x1000, len=32, memwrite, zero-wait slave: AW awaddr=0x1000 awlen=3 awsize=5 awburst=1; 4 W beats with data slices 0..3; wstrb=FFFFFFFF; wlast on beat 3; bresp OKAY; in_ready back high; no err_pulse.
- len=11 (2 beats, rem=3): awlen=1; beat0 wstrb=FFFFFFFF; beat1 wstrb=00000FFF with wlast=1.
- Backpressure: awready low 5 cycles, then wready toggling 1/0: AW fields stable while stalled; each beat's data/strb held until its handshake; beat order preserved.
- Dropped chunks: in_is_memwrite=0 (len=8), then len=0, then len=40: each consumed in one cycle, no AW issued, err_pulse once per chunk; with AXI4_ENC_ERR_CNT_EN, err_cnt=3.
- bresp=2'b10 on len=8 chunk: single-beat burst completes, err_pulse one cycle after B handshake; the next chunk is accepted normally.
- rst asserted during beat 2 of a 4-beat burst: same cycle all valids drop, busy=0, in_ready=1; a following chunk addr=0x2000 len=8 is issued correctly with awlen=0.
